// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 keyboard controller
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronisers, falling-edge strobe, frame check, optional timeout
// Optional feature macro: PS2_KBD_TIMEOUT_EN (mid-frame idle abort after TIMEOUT_CYC cycles).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   ps2_clk, ps2_data    - raw asynchronous keyboard lines
//   byte_valid           - one-cycle pulse, byte_data holds a checked byte
//   byte_data[7:0]       - received data byte
//   frame_err            - one-cycle pulse on bad start/stop/parity or timeout
module ps2_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic [2:0] clk_sync;
    logic [1:0] data_dly;
    logic [3:0] bit_cnt;
    logic [9:0] shift_buf;
    logic       strobe;
    logic       data_bit;
    logic       frame_ok;
    logic       timeout_hit;

    // Data is delayed two flops so it lines up with clk_sync[1], the
    // newer half of the edge detector.
    assign strobe   = clk_sync[2] & ~clk_sync[1];
    assign data_bit = data_dly[1];

    // shift_buf[0] = start, [8:1] = data LSB first, [9] = parity; the stop
    // bit is the live sample on the 11th strobe.
    assign frame_ok = ~shift_buf[0] & data_bit & (^shift_buf[9:1]);

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || strobe || (bit_cnt == 4'd0)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (bit_cnt != 4'd0) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= '0;
            data_dly   <= '0;
            bit_cnt    <= '0;
            shift_buf  <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ps2_clk};
            data_dly   <= {data_dly[0], ps2_data};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (strobe) begin
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_buf[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift_buf <= {data_bit, shift_buf[9:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end else if (timeout_hit) begin
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard controller: receiver, prefix decoder FSM and event FIFO
// Optional feature macro: PS2_KBD_TIMEOUT_EN (enables the receiver mid-frame timeout).
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   ps2_clk, ps2_data                   - raw keyboard lines
//   evt_valid, evt_ready                - event FIFO head handshake
//   evt_code, evt_ext, evt_break        - head event fields
//   frame_err                           - one-cycle pulse on bad frame or timeout
//   overflow, ovf_clr                   - sticky drop flag and its clear
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic       byte_valid;
    logic [7:0] byte_data;

    ps2_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    dec_state_t state, state_nxt;
    logic       push;
    ps2_evt_t   push_evt;
    logic       is_prefix;

    assign is_prefix = (byte_data == PS2_PREFIX_EXT) || (byte_data == PS2_PREFIX_BRK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DEC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_err) begin
            state_nxt = DEC_IDLE;
        end else if (byte_valid) begin
            case (state)
                DEC_IDLE: begin
                    if (byte_data == PS2_PREFIX_EXT)      state_nxt = DEC_EXT;
                    else if (byte_data == PS2_PREFIX_BRK) state_nxt = DEC_BRK;
                end
                DEC_EXT: begin
                    if (byte_data == PS2_PREFIX_BRK)      state_nxt = DEC_EXT_BRK;
                    else if (byte_data != PS2_PREFIX_EXT) state_nxt = DEC_IDLE;
                end
                DEC_BRK: begin
                    if (byte_data == PS2_PREFIX_EXT)      state_nxt = DEC_EXT_BRK;
                    else if (byte_data != PS2_PREFIX_BRK) state_nxt = DEC_IDLE;
                end
                DEC_EXT_BRK: begin
                    if (!is_prefix)                       state_nxt = DEC_IDLE;
                end
                default: state_nxt = DEC_IDLE;
            endcase
        end
    end

    // Any non-prefix byte completes an event; the prefixes seen so far are
    // encoded in the current state.
    always_comb begin
        push          = byte_valid & ~is_prefix;
        push_evt.ext  = (state == DEC_EXT) || (state == DEC_EXT_BRK);
        push_evt.brk  = (state == DEC_BRK) || (state == DEC_EXT_BRK);
        push_evt.code = byte_data;
    end

    ps2_evt_t      mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, push_ok, drop;
    ps2_evt_t      head;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - scoreboard testbench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int H     = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
    logic [7:0] evt_code;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_ext  (evt_ext),
        .evt_break(evt_break),
        .frame_err(frame_err),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_ferr = 0;
    int ferr_seen = 0;
    int valid_cyc = 0;
    int stop_fall_cyc = 0;
    bit lat_check = 1'b0;
    bit rand_ready = 1'b0;
    bit exp_ext = 1'b0;
    bit exp_brk = 1'b0;
    bit exp_ovf = 1'b0;
    logic [9:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) ferr_seen++;
            if (evt_valid) valid_cyc++;
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=%0h expected=none",
                             {evt_ext, evt_break, evt_code});
                end else begin
                    check("event", int'({evt_ext, evt_break, evt_code}), int'(exp_q.pop_front()));
                    if (lat_check) begin
                        check("event_latency", cyc - stop_fall_cyc, 4);
                        lat_check = 1'b0;
                    end
                end
            end
        end
    end

    // Reference: prefixes accumulate as flags, any other good byte forms an
    // event; an errored frame discards pending prefixes.
    task automatic model_byte(input logic [7:0] b, input bit err);
        if (err) begin
            exp_ferr++;
            exp_ext = 1'b0;
            exp_brk = 1'b0;
        end else if (b == 8'hE0) begin
            exp_ext = 1'b1;
        end else if (b == 8'hF0) begin
            exp_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({exp_ext, exp_brk, b});
            exp_ext = 1'b0;
            exp_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
        logic par;
        par = (~^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        model_byte(b, bad);
        send_bits(frame_bits(b, bad), 11);
        wait_cyc(H);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            wait_cyc(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        wait_cyc(10);
    endtask

    task automatic fill_overflow();
        evt_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        wait_cyc(10);
        check("ovf_set", int'(overflow), int'(exp_ovf));
        check("ovf_held_valid", int'(evt_valid), 1);
        evt_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_sticky", int'(overflow), 1);
    endtask

    initial begin
        int v0;
        logic [7:0] b;

        wait_cyc(4);
        check("reset_evt_valid", int'(evt_valid), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        wait_cyc(5);

        v0 = valid_cyc;
        lat_check = 1'b1;
        send_frame(8'h1C, 1'b0);
        drain("make_drain");
        check("make_valid_cycles", valid_cyc - v0, 1);

        send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
        drain("brk_ext_drain");

        v0 = valid_cyc;
        send_frame(8'hE0, 1'b0);
        wait_cyc(20);
        check("prefix_no_event", valid_cyc - v0, 0);
        send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
        drain("prefix_drain");

        send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b1); send_frame(8'h1C, 1'b0);
        drain("ferr_drain");
        check("ferr_count", ferr_seen, exp_ferr);

        fill_overflow();
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        wait_cyc(1);
        check("ovf_clr", int'(overflow), 0);

`ifdef PS2_KBD_TIMEOUT_EN
        send_bits(frame_bits(8'h55, 1'b0), 4);
        exp_ferr++;
        exp_ext = 1'b0;
        exp_brk = 1'b0;
        wait_cyc(120);
        check("timeout_ferr", ferr_seen, exp_ferr);
        send_frame(8'h1C, 1'b0);
        drain("timeout_drain");
`endif

        fill_overflow();
        send_frame(8'hE0, 1'b0);
        send_bits(frame_bits(8'h33, 1'b0), 6);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        exp_ext = 1'b0;
        exp_brk = 1'b0;
        exp_ovf = 1'b0;
        wait_cyc(1);
        check("reset_clears_ovf", int'(overflow), 0);
        check("reset_clears_valid", int'(evt_valid), 0);
        wait_cyc(5);
        send_frame(8'h2A, 1'b0);
        drain("reset_midframe_drain");
        check("reset_midframe_ovf", int'(overflow), 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, ($urandom_range(0, 7) == 0));
        end
        rand_ready = 1'b0;
        evt_ready = 1'b1;
        drain("random_drain");
        check("final_ferr_count", ferr_seen, exp_ferr);
        check("final_overflow", int'(overflow), int'(exp_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
